// File: rtl/mem_wb_stage.sv
// MEM + WB stage: accepts EX results, runs one load/store at a time on the dmem
// req/ack port, and produces a single-cycle register-file write pulse.
module mem_wb_stage #(
  parameter int D_WIDTH = 32,
  parameter int N_REGS  = 32,
  parameter int RF_SIZE = $clog2(N_REGS),
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [D_WIDTH-1:0] alu_result,
  input  logic [D_WIDTH-1:0] store_data,
  input  logic [RF_SIZE-1:0] rd,
  input  logic               reg_write,
  input  logic               mem_we,
  input  logic               mem_re,
  input  logic               mem_to_reg,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  input  logic               dmem_ack,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               wb_we,
  output logic [RF_SIZE-1:0] wb_rd,
  output logic [D_WIDTH-1:0] wb_data,
  output logic               err_misalign,
  output logic               err_timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [D_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [RF_SIZE-1:0] rd_q, rd_d;
  logic               rw_q, rw_d;
  logic               m2r_q, m2r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wb_we_q, wb_we_d;
  logic [RF_SIZE-1:0] wb_rd_q, wb_rd_d;
  logic [D_WIDTH-1:0] wb_data_q, wb_data_d;
  logic               mis_q, mis_d;
  logic               tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    m2r_d     = m2r_q;
    cnt_d     = cnt_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    mis_d     = 1'b0;
    tmo_d     = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!mem_we && !mem_re) begin
            wb_we_d   = reg_write && (rd != '0);
            wb_rd_d   = rd;
            wb_data_d = alu_result;
          end else if (alu_result[1:0] != 2'b00) begin
            mis_d = 1'b1;
          end else begin
            // A store wins when both mem_we and mem_re are set.
            state_d = MEM;
            req_d   = 1'b1;
            we_d    = mem_we;
            addr_d  = alu_result;
            wdata_d = store_data;
            rd_d    = rd;
            rw_d    = reg_write;
            m2r_d   = mem_to_reg;
            cnt_d   = '0;
          end
        end
      end
      MEM: begin
        // Ack has priority over the timeout expiring in the same cycle.
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_we_d   = rw_q && (rd_q != '0);
            wb_rd_d   = rd_q;
            wb_data_d = m2r_q ? dmem_rdata : addr_q;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          req_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      cnt_q     <= cnt_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      mis_q     <= mis_d;
      tmo_q     <= tmo_d;
    end
  end

  assign stall        = (state_q == MEM);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = mis_q;
  assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_misalign, err_timeout;

  int total = 0;
  int bad = 0;
  int req_cycles;

  mem_wb_stage #(.D_WIDTH(32), .N_REGS(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_we(mem_we),
    .mem_re(mem_re), .mem_to_reg(mem_to_reg), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                       input logic rw, input logic we, input logic re, input logic m2r);
    ex_valid = 1'b1; alu_result = a; store_data = sd; rd = r;
    reg_write = rw; mem_we = we; mem_re = re; mem_to_reg = m2r;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0; reg_write = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_tmo", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    step();

    // non-memory op: one-cycle writeback
    issue(32'h1234, 0, 5'd5, 1, 0, 0, 0);
    step();
    idle_in();
    chk("alu_wb_we", 32'(wb_we), 32'd1);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_stall", 32'(stall), 32'd0);
    step();
    chk("alu_wb_pulse", 32'(wb_we), 32'd0);
    $display("txn alu rd=5 data=%h", wb_data);

    // back-to-back non-mem ops, then rd=0 suppresses the write
    issue(32'h11, 0, 5'd3, 1, 0, 0, 0);
    step();
    issue(32'h22, 0, 5'd4, 1, 0, 0, 0);
    chk("b2b0_rd", 32'(wb_rd), 32'd3);
    chk("b2b0_data", wb_data, 32'h11);
    step();
    issue(32'h33, 0, 5'd0, 1, 0, 0, 0);
    chk("b2b1_we", 32'(wb_we), 32'd1);
    chk("b2b1_data", wb_data, 32'h22);
    step();
    idle_in();
    chk("rd0_we", 32'(wb_we), 32'd0);
    $display("txn b2b alu x3");

    // load with ack in third request cycle
    issue(32'h100, 0, 5'd7, 1, 0, 1, 1);
    step();
    idle_in();
    chk("ld_req1", 32'(dmem_req), 32'd1);
    chk("ld_stall1", 32'(stall), 32'd1);
    chk("ld_addr1", dmem_addr, 32'h100);
    chk("ld_we", 32'(dmem_we), 32'd0);
    step();
    chk("ld_stall2", 32'(stall), 32'd1);
    chk("ld_addr2", dmem_addr, 32'h100);
    step();
    chk("ld_stall3", 32'(stall), 32'd1);
    chk("ld_addr3", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack = 1'b0;
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    chk("ld_stall_drop", 32'(stall), 32'd0);
    chk("ld_wb_we", 32'(wb_we), 32'd1);
    chk("ld_wb_rd", 32'(wb_rd), 32'd7);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    $display("txn load addr=100 data=%h", wb_data);

    // load with mem_to_reg=0 writes back the address, immediate ack
    issue(32'h200, 0, 5'd9, 1, 0, 1, 0);
    step();
    idle_in();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_ack = 1'b0;
    chk("ldaddr_we", 32'(wb_we), 32'd1);
    chk("ldaddr_data", wb_data, 32'h200);
    $display("txn load m2r=0 data=%h", wb_data);

    // store (both we and re set -> store), immediate ack
    issue(32'h40, 32'hA5A5A5A5, 5'd2, 1, 1, 1, 1);
    step();
    idle_in();
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h40);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    chk("st_no_wb", 32'(wb_we), 32'd0);
    $display("txn store addr=40");

    // misaligned load
    issue(32'h102, 0, 5'd7, 1, 0, 1, 1);
    step();
    idle_in();
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_pulse", 32'(err_misalign), 32'd1);
    chk("mis_wb", 32'(wb_we), 32'd0);
    step();
    chk("mis_clear", 32'(err_misalign), 32'd0);
    chk("mis_req2", 32'(dmem_req), 32'd0);
    $display("txn misaligned addr=102");

    // timeout: req stays up for TIMEOUT cycles
    issue(32'h300, 0, 5'd6, 1, 0, 1, 1);
    step();
    idle_in();
    req_cycles = 0;
    for (int i = 0; i < 40 && dmem_req; i++) begin
      req_cycles++;
      step();
    end
    chk("tmo_cycles", 32'(req_cycles), 32'd16);
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    chk("tmo_no_wb", 32'(wb_we), 32'd0);
    issue(32'h55, 0, 5'd8, 1, 0, 0, 0);
    step();
    idle_in();
    chk("post_tmo_we", 32'(wb_we), 32'd1);
    chk("post_tmo_data", wb_data, 32'h55);
    step();
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    $display("txn timeout req_cycles=%0d", req_cycles);

    // asynchronous reset mid-transaction
    issue(32'h400, 0, 5'd10, 1, 0, 1, 1);
    step();
    idle_in();
    chk("ar_req_pre", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", 32'(dmem_req), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_wb_we", 32'(wb_we), 32'd0);
    chk("ar_tmo", 32'(err_timeout), 32'd0);
    #1 rst = 1'b0;
    step();
    issue(32'h80, 0, 5'd11, 1, 0, 1, 1);
    step();
    idle_in();
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    step();
    dmem_ack = 1'b0;
    chk("ar_post_we", 32'(wb_we), 32'd1);
    chk("ar_post_rd", 32'(wb_rd), 32'd11);
    chk("ar_post_data", wb_data, 32'h13579BDF);
    $display("txn async reset then load data=%h", wb_data);

    // ack arriving in the expiry cycle still completes normally
    issue(32'h500, 0, 5'd12, 1, 0, 1, 1);
    step();
    idle_in();
    for (int i = 0; i < 15; i++) step();
    chk("edge_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADCAFE;
    step();
    dmem_ack = 1'b0;
    chk("edge_we", 32'(wb_we), 32'd1);
    chk("edge_data", wb_data, 32'h0BADCAFE);
    chk("edge_tmo", 32'(err_timeout), 32'd0);
    $display("txn ack at expiry data=%h", wb_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage pair (MEM + WB) of the 5-stage core.
- Takes EX-stage results and control.
- Runs load/store transactions on the data-memory req/ack interface.
- Drives the register-file write port (wb_we, wb_rd, wb_data), which is the write side of the decode stage's RF read.
- Stalls upstream during multi-cycle memory accesses.

Parameters:
- D_WIDTH, 32, data/address width
- N_REGS, 32, register count
- RF_SIZE, $clog2(N_REGS), register index width
- TIMEOUT, 16, max cycles waiting for dmem_ack before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX presents a valid instruction
- alu_result  in  D_WIDTH  ALU output; memory address for load/store
- store_data  in  D_WIDTH  rs2 value for stores
- rd  in  RF_SIZE  destination register
- reg_write  in  1  instruction writes rd
- mem_we  in  1  store
- mem_re  in  1  load
- mem_to_reg  in  1  writeback selects load data
- stall  out  1  upstream must hold EX outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  request is write
- dmem_addr  out  D_WIDTH  word address (byte-addressed, aligned)
- dmem_wdata  out  D_WIDTH  store data
- dmem_ack  in  1  request complete
- dmem_rdata  in  D_WIDTH  load data, valid with dmem_ack
- wb_we  out  1  RF write enable
- wb_rd  out  RF_SIZE  RF write address
- wb_data  out  D_WIDTH  RF write data
- err_misalign  out  1  one-cycle pulse, misaligned load/store dropped
- err_timeout  out  1  sticky; memory timeout occurred

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, err_timeout cleared. Async assertion mid-transaction drops dmem_req immediately; the transaction is abandoned.
- States: IDLE, MEM.
- stall = (state==MEM), combinational from state only.
- Accept: ex_valid && state==IDLE. In MEM, inputs are ignored; upstream holds them.
- Non-memory op (mem_we==0 && mem_re==0) accepted at edge T: wb_we=reg_write&&(rd!=0), wb_rd=rd, wb_data=alu_result, all registered and valid the cycle after T. Single-cycle pulse, 0 otherwise.
- Memory op with alu_result[1:0]!=0: no request, no writeback, err_misalign high one cycle after accept.
- Aligned memory op accepted at T:
  - Capture dmem_addr=alu_result, dmem_wdata=store_data, dmem_we=mem_we, plus rd, reg_write, mem_to_reg.
  - dmem_req=1 from T+1; state=MEM.
  - dmem_addr, dmem_wdata and dmem_we are held stable while dmem_req=1.
- dmem_ack sampled only while dmem_req=1. Earliest ack is the first req cycle. At the ack edge: dmem_req->0, state->IDLE.
- Load completion: wb_we=reg_write&&(rd!=0), wb_data = mem_to_reg ? dmem_rdata : captured address; valid the cycle after ack. Total latency with immediate ack is 2 cycles after accept.
- Store completion: no writeback.
- mem_we && mem_re both set: treated as store.
- Timeout counter:
  - Cleared on entering MEM; increments each MEM cycle without ack.
  - On reaching TIMEOUT-1 with no ack: dmem_req->0, state->IDLE, no writeback, err_timeout=1 until reset.
  - Ack in the same cycle as expiry: ack wins, normal completion.
- Back-to-back:
  - A new instruction is accepted the cycle stall drops.
  - Non-memory ops with ex_valid held give one writeback per cycle.
  - wb_* never asserts for two instructions in the same cycle.

Test Plan:
- Reset, then ex_valid with non-mem op, alu_result=0x1234, rd=5, reg_write=1 at T -> wb_we=1, wb_rd=5, wb_data=0x1234 during T+1 only; stall stays 0.
- Load, alu_result=0x100, rd=7, ack 3 cycles after req with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr stable at 0x100, wb_data=0xDEADBEEF, wb_rd=7 the cycle after ack.
- Store, alu_result=0x40, store_data=0xA5A5A5A5, immediate ack -> dmem_we=1, dmem_wdata=0xA5A5A5A5 for one req cycle; wb_we never asserts.
- Load to 0x102 -> no dmem_req, err_misalign one-cycle pulse, wb_we stays 0.
- Load with ack never returned, TIMEOUT=16 -> req drops after 16 cycles, err_timeout=1 sticky, no writeback; next non-mem op proceeds normally.
- Async rst mid-MEM (req high) -> dmem_req, stall, wb_we all 0 immediately; first post-reset op completes normally.
